tick_gen_multi: RTL and testbench

//  Parametrised successor to the single-output power-of-two clock divider.

---
 rtl/tick_gen_multi.sv | 102 ++++++++++
 tb/tb_tick_gen_multi.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: CHANNELS independent clock-enable tick generators
// with programmable period, free-run/one-shot mode, level and busy.
module tick_gen_multi #(
    parameter int unsigned     CHANNELS       = 2,
    parameter int unsigned     BITS           = 21,
    parameter logic [BITS-1:0] DEFAULT_PERIOD = BITS'(4)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CHANNELS-1:0]      en,
    input  logic [CHANNELS-1:0]      oneshot,
    input  logic [CHANNELS-1:0]      start,
    input  logic [CHANNELS-1:0]      load,
    input  logic [CHANNELS*BITS-1:0] period,
    output logic [CHANNELS-1:0]      tick,
    output logic [CHANNELS-1:0]      level,
    output logic [CHANNELS-1:0]      busy
);

    localparam logic [BITS-1:0] ONE = BITS'(1);

    logic [BITS-1:0]     cnt_q  [CHANNELS];
    logic [BITS-1:0]     cnt_d  [CHANNELS];
    logic [BITS-1:0]     preg_q [CHANNELS];
    logic [BITS-1:0]     preg_d [CHANNELS];
    logic [BITS-1:0]     p_eff  [CHANNELS];
    logic [CHANNELS-1:0] run;
    logic [CHANNELS-1:0] term;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] busy_q, busy_d;

    // Effective period (0 behaves as 1), run qualifier and terminal detect
    always_comb begin
        p_eff = '{default: '0};
        run   = '0;
        term  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            p_eff[i] = (preg_q[i] == '0) ? ONE : preg_q[i];
            run[i]   = en[i] & (~oneshot[i] | busy_q[i]);
            term[i]  = run[i] & (cnt_q[i] == p_eff[i] - ONE);
        end
    end

    // Per-channel next state: en-off > load > start > terminal > count
    always_comb begin
        cnt_d   = cnt_q;
        preg_d  = preg_q;
        tick_d  = '0;
        level_d = level_q;
        busy_d  = busy_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!en[i]) begin
                cnt_d[i]  = '0;
                busy_d[i] = 1'b0;
            end else if (load[i]) begin
                preg_d[i] = period[i*BITS +: BITS];
                cnt_d[i]  = '0;
            end else if (start[i] && oneshot[i]) begin
                cnt_d[i]  = '0;
                busy_d[i] = 1'b1;
            end else if (term[i]) begin
                cnt_d[i]   = '0;
                tick_d[i]  = 1'b1;
                level_d[i] = ~level_q[i];
                busy_d[i]  = 1'b0;
            end else if (run[i]) begin
                cnt_d[i] = cnt_q[i] + ONE;
            end else begin
                cnt_d[i] = '0;
            end
            // busy only has meaning in one-shot mode
            if (!oneshot[i]) begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= '0;
                preg_q[i] <= DEFAULT_PERIOD;
            end
            tick_q  <= '0;
            level_q <= '0;
            busy_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            preg_q  <= preg_d;
            tick_q  <= tick_d;
            level_q <= level_d;
            busy_q  <= busy_d;
        end
    end

    assign tick  = tick_q;
    assign level = level_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed scenarios plus random traffic checked
// against a countdown reference model of each tick channel.
module tb_tick_gen_multi;

    localparam int CH = 2;
    localparam int B  = 21;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   en, oneshot, start, load;
    logic [CH*B-1:0] period;
    logic [CH-1:0]   tick, level, busy;

    int errors = 0;
    int checks = 0;

    // Reference model: edges remaining until the next tick
    int unsigned m_preg [CH];
    int unsigned m_rem  [CH];
    logic [CH-1:0] m_tick, m_level, m_busy;
    int tick0_seen;

    tick_gen_multi #(.CHANNELS(CH), .BITS(B)) dut (
        .clk(clk), .rst(rst), .en(en), .oneshot(oneshot),
        .start(start), .load(load), .period(period),
        .tick(tick), .level(level), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int unsigned eff(input int unsigned p);
        return (p == 0) ? 1 : p;
    endfunction

    task automatic model_edge();
        for (int i = 0; i < CH; i++) begin
            if (rst) begin
                m_preg[i]  = 4;
                m_rem[i]   = 4;
                m_tick[i]  = 1'b0;
                m_level[i] = 1'b0;
                m_busy[i]  = 1'b0;
            end else if (!en[i]) begin
                m_rem[i]  = eff(m_preg[i]);
                m_tick[i] = 1'b0;
                m_busy[i] = 1'b0;
            end else if (load[i]) begin
                m_preg[i] = int'(period[i*B +: B]);
                m_rem[i]  = eff(m_preg[i]);
                m_tick[i] = 1'b0;
                if (!oneshot[i]) m_busy[i] = 1'b0;
            end else if (start[i] && oneshot[i]) begin
                m_rem[i]  = eff(m_preg[i]);
                m_busy[i] = 1'b1;
                m_tick[i] = 1'b0;
            end else if (!oneshot[i] || m_busy[i]) begin
                m_rem[i] = m_rem[i] - 1;
                m_tick[i] = 1'b0;
                if (m_rem[i] == 0) begin
                    m_tick[i]  = 1'b1;
                    m_level[i] = ~m_level[i];
                    m_rem[i]   = eff(m_preg[i]);
                    m_busy[i]  = 1'b0;
                end
                if (!oneshot[i]) m_busy[i] = 1'b0;
            end else begin
                m_rem[i]  = eff(m_preg[i]);
                m_tick[i] = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        tick0_seen += int'(tick[0]);
        checks++;
        assert (tick === m_tick) else begin
            errors++;
            $error("FAIL tick obs=%b exp=%b t=%0t", tick, m_tick, $time);
        end
        checks++;
        assert (level === m_level) else begin
            errors++;
            $error("FAIL level obs=%b exp=%b t=%0t", level, m_level, $time);
        end
        checks++;
        assert (busy === m_busy) else begin
            errors++;
            $error("FAIL busy obs=%b exp=%b t=%0t", busy, m_busy, $time);
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic set_p(input int ch, input int unsigned p);
        period[ch*B +: B] = B'(p);
    endtask

    initial begin
        rst = 1'b1; en = '0; oneshot = '0;
        start = '0; load = '0; period = '0;
        tick0_seen = 0;
        steps(2);
        checks++;
        assert ({tick, level, busy} === 6'b0) else begin
            errors++;
            $error("FAIL reset obs=%b exp=%b", {tick, level, busy}, 6'b0);
        end

        // 1: free-run default period 4 on ch0 only
        rst = 1'b0; en = 2'b01;
        tick0_seen = 0;
        steps(16);
        checks++;
        assert (tick0_seen === 4) else begin
            errors++;
            $error("FAIL freerun_count obs=%0d exp=%0d", tick0_seen, 4);
        end
        checks++;
        assert ({tick[1], level[1], busy[1]} === 3'b0) else begin
            errors++;
            $error("FAIL ch1_idle obs=%b exp=%b",
                   {tick[1], level[1], busy[1]}, 3'b0);
        end

        // 2: reload period 10 mid-count
        steps(2);
        set_p(0, 10); load = 2'b01;
        step();
        load = '0;
        steps(25);

        // 3: period 0 and period 1 both tick every cycle
        set_p(0, 0); load = 2'b01;
        step();
        load = '0;
        steps(6);
        set_p(0, 1); load = 2'b01;
        step();
        load = '0;
        steps(6);

        // 4: one-shot, period 5, single start
        oneshot = 2'b01; set_p(0, 5); load = 2'b01;
        step();
        load = '0; start = 2'b01;
        step();
        start = '0;
        tick0_seen = 0;
        steps(8);
        checks++;
        assert (tick0_seen === 1) else begin
            errors++;
            $error("FAIL oneshot_count obs=%0d exp=%0d", tick0_seen, 1);
        end

        // 5: restart on the terminal edge
        start = 2'b01;
        step();
        start = '0;
        steps(4);
        start = 2'b01;
        step();
        start = '0;
        steps(7);

        // 6: free-run, en drop mid-count, then rst mid-count
        oneshot = '0; set_p(0, 6); load = 2'b01;
        step();
        load = '0;
        steps(9);
        en = 2'b00;
        step();
        en = 2'b01;
        steps(8);
        rst = 1'b1;
        step();
        rst = 1'b0;
        steps(10);

        // Random traffic on both channels
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < CH; i++) begin
                en[i] = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 15) == 0) oneshot[i] = ~oneshot[i];
                start[i] = ($urandom_range(0, 7) == 0);
                load[i]  = ($urandom_range(0, 15) == 0);
                set_p(i, $urandom_range(0, 7));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
